// File: rtl/mem_access.sv
// LC-3b memory stage: drives the data-cache handshake for word, byte and
// indirect accesses, stalls upstream while waiting, and registers writeback.
module mem_access #(
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [3:0]  opcode_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [15:0] address_in,
  input  logic [15:0] result_in,
  input  logic [2:0]  dr_in,
  output logic [15:0] dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [1:0]  dmem_byte_enable,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        mem_stall,
  output logic        valid_out,
  output logic [15:0] data_out,
  output logic [2:0]  dr_out,
  output logic        err_timeout
);

  localparam logic [3:0] OP_LDB = 4'b0010;
  localparam logic [3:0] OP_STB = 4'b0011;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;

  typedef enum logic [1:0] {IDLE, ACCESS, IND_PTR, IND_DATA} state_t;

  state_t               state_q, state_d;
  logic [15:0]          ptr_q, ptr_d;
  logic                 gap_q, gap_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 valid_q, valid_d;
  logic [15:0]          data_q, data_d;
  logic [2:0]           dr_q, dr_d;

  logic        is_mem, is_byte, is_ind, is_store, start;
  logic        req, wr, stall, clr;
  logic [7:0]  load_byte;
  logic [15:0] load_data;

  always_comb begin
    is_mem   = opcode_in inside {OP_LDR, OP_STR, OP_LDB, OP_STB, OP_LDI, OP_STI};
    is_byte  = opcode_in inside {OP_LDB, OP_STB};
    is_ind   = opcode_in inside {OP_LDI, OP_STI};
    is_store = opcode_in inside {OP_STR, OP_STB, OP_STI};
    start    = valid_in & (mem_read_in | mem_write_in) & is_mem;

    load_byte = address_in[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];
    load_data = is_byte ? {{8{load_byte[7]}}, load_byte} : dmem_rdata;

    state_d = state_q;
    ptr_d   = ptr_q;
    gap_d   = 1'b0;
    err_d   = err_q;
    valid_d = 1'b0;
    data_d  = data_q;
    dr_d    = dr_q;
    req     = 1'b0;
    wr      = 1'b0;
    stall   = 1'b0;
    clr     = 1'b0;

    dmem_address     = {address_in[15:1], 1'b0};
    dmem_byte_enable = 2'b11;
    dmem_wdata       = result_in;
    if (is_byte) begin
      dmem_address = address_in;
      if (is_store) begin
        dmem_byte_enable = address_in[0] ? 2'b10 : 2'b01;
        dmem_wdata       = {result_in[7:0], result_in[7:0]};
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          req     = 1'b1;
          wr      = is_store & ~is_ind;
          stall   = 1'b1;
          clr     = 1'b1;
          state_d = is_ind ? IND_PTR : ACCESS;
        end else begin
          valid_d = valid_in;
          data_d  = result_in;
          dr_d    = dr_in;
        end
      end
      ACCESS: begin
        req = 1'b1;
        wr  = is_store;
        if (dmem_resp) begin
          state_d = IDLE;
          valid_d = 1'b1;
          data_d  = is_store ? result_in : load_data;
          dr_d    = dr_in;
        end else begin
          stall = 1'b1;
        end
      end
      IND_PTR: begin
        req   = 1'b1;
        stall = 1'b1;
        if (dmem_resp) begin
          ptr_d   = {dmem_rdata[15:1], 1'b0};
          gap_d   = 1'b1;
          state_d = IND_DATA;
        end
      end
      IND_DATA: begin
        dmem_address     = ptr_q;
        dmem_byte_enable = 2'b11;
        dmem_wdata       = result_in;
        // First cycle here is the mandatory idle gap between the two accesses.
        if (gap_q) begin
          stall = 1'b1;
          clr   = 1'b1;
        end else begin
          req = 1'b1;
          wr  = is_store;
          if (dmem_resp) begin
            state_d = IDLE;
            valid_d = 1'b1;
            data_d  = is_store ? result_in : dmem_rdata;
            dr_d    = dr_in;
          end else begin
            stall = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (stall && !(&cnt_q)) begin
      cnt_d = cnt_q + TIMEOUT_W'(1);
    end
    err_d = err_q | (&cnt_d);

    dmem_read  = req & ~wr & ~reset;
    dmem_write = req & wr & ~reset;
    mem_stall  = stall & ~reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gap_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      dr_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      dr_q    <= dr_d;
    end
  end

  assign valid_out   = valid_q;
  assign data_out    = data_q;
  assign dr_out      = dr_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed and random operations against
// an arithmetic reference of addressing, lane and latency rules.
module tb_mem_access;

  localparam logic [3:0] OP_ADD = 4'h1, OP_LDB = 4'h2, OP_STB = 4'h3, OP_AND = 4'h5,
                         OP_LDR = 4'h6, OP_STR = 4'h7, OP_LDI = 4'hA, OP_STI = 4'hB;

  logic        clk, reset, valid_in, mem_read_in, mem_write_in, dmem_resp;
  logic [3:0]  opcode_in;
  logic [15:0] address_in, result_in, dmem_rdata;
  logic [2:0]  dr_in;
  logic [15:0] dmem_address, dmem_wdata, data_out;
  logic        dmem_read, dmem_write, mem_stall, valid_out, err_timeout;
  logic [1:0]  dmem_byte_enable;
  logic [2:0]  dr_out;

  int checks = 0;
  int failures = 0;

  mem_access #(.TIMEOUT_W(8)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .opcode_in(opcode_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .address_in(address_in),
    .result_in(result_in), .dr_in(dr_in), .dmem_address(dmem_address),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_byte_enable(dmem_byte_enable),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_stall(mem_stall), .valid_out(valid_out), .data_out(data_out), .dr_out(dr_out),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_mem(input logic [3:0] op);
    return op inside {OP_LDR, OP_STR, OP_LDB, OP_STB, OP_LDI, OP_STI};
  endfunction

  function automatic bit is_st(input logic [3:0] op);
    return op inside {OP_STR, OP_STB, OP_STI};
  endfunction

  function automatic logic [15:0] sext_byte(input logic [15:0] rd, input bit odd);
    int b;
    b = odd ? int'(rd) / 256 : int'(rd) % 256;
    if (b >= 128) b = b - 256;
    return 16'(b);
  endfunction

  task automatic bubble();
    valid_in = 1'b0; opcode_in = OP_ADD; mem_read_in = 1'b0; mem_write_in = 1'b0;
    address_in = '0; result_in = '0; dr_in = '0;
  endtask

  task automatic chk_req(input string tag, input bit rd, input bit wr, input logic [15:0] a,
                         input bit chk_be, input logic [1:0] be, input logic [15:0] wd,
                         input bit stall);
    chk({tag, "_rd"}, dmem_read, rd);
    chk({tag, "_wr"}, dmem_write, wr);
    chk({tag, "_addr"}, dmem_address, a);
    if (chk_be) chk({tag, "_be"}, dmem_byte_enable, be);
    if (wr) chk({tag, "_wdata"}, dmem_wdata, wd);
    chk({tag, "_stall"}, mem_stall, stall);
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic do_op(input logic [3:0] op, input logic [15:0] addr, input logic [15:0] res,
                       input logic [2:0] dr, input bit vld, input int lat1,
                       input logic [15:0] rd1, input int lat2, input logic [15:0] rd2);
    bit mem, store, byt, ind, wr1;
    logic [15:0] a1, wd, ptr, expd;
    logic [1:0] be;
    mem   = vld && is_mem(op);
    store = is_st(op);
    byt   = op inside {OP_LDB, OP_STB};
    ind   = op inside {OP_LDI, OP_STI};
    valid_in = vld; opcode_in = op; address_in = addr; result_in = res; dr_in = dr;
    mem_read_in = is_mem(op) && !store; mem_write_in = is_mem(op) && store;
    dmem_resp = 1'b0; dmem_rdata = 16'($urandom);
    #1;
    if (!mem) begin
      chk("pass_stall", mem_stall, 0);
      chk("pass_strobes", {dmem_read, dmem_write}, 0);
      @(negedge clk);
      chk("pass_valid", valid_out, vld);
      chk("pass_data", data_out, res);
      chk("pass_dr", dr_out, dr);
      return;
    end
    a1  = byt ? addr : addr & 16'hFFFE;
    be  = (op == OP_STB) ? ((addr % 2 == 1) ? 2'b10 : 2'b01) : 2'b11;
    wd  = (op == OP_STB) ? (res % 256) * 16'h0101 : res;
    wr1 = store && !ind;
    for (int k = 0; k <= lat1; k++) begin
      if (k > 0) begin
        @(negedge clk);
        dmem_resp = (k == lat1);
        dmem_rdata = (k == lat1) ? rd1 : 16'($urandom);
        #1;
        chk("wait_valid_out", valid_out, 0);
      end
      chk_req("acc1", !wr1, wr1, a1, op != OP_LDB, be, wd, ind || (k != lat1));
    end
    if (ind) begin
      ptr = rd1 & 16'hFFFE;
      @(negedge clk);
      dmem_resp = 1'b0;
      #1;
      chk("gap_strobes", {dmem_read, dmem_write}, 0);
      chk("gap_stall", mem_stall, 1);
      for (int k = 0; k <= lat2; k++) begin
        @(negedge clk);
        dmem_resp = (k == lat2);
        dmem_rdata = (k == lat2) ? rd2 : 16'($urandom);
        #1;
        chk_req("acc2", !store, store, ptr, 1'b1, 2'b11, res, k != lat2);
      end
    end
    if (store)     expd = res;
    else if (ind)  expd = rd2;
    else if (byt)  expd = sext_byte(rd1, addr % 2 == 1);
    else           expd = rd1;
    @(negedge clk);
    dmem_resp = 1'b0;
    chk("done_valid", valid_out, 1);
    chk("done_data", data_out, expd);
    chk("done_dr", dr_out, dr);
    bubble();
  endtask

  logic [3:0] ops [8];

  initial begin
    ops = '{OP_ADD, OP_AND, OP_LDR, OP_STR, OP_LDB, OP_STB, OP_LDI, OP_STI};
    reset = 1'b1; dmem_resp = 1'b0; dmem_rdata = '0;
    bubble();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", valid_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_dr", dr_out, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_strobes", {dmem_read, dmem_write}, 0);
    @(negedge clk);
    reset = 1'b0;

    do_op(OP_LDR, 16'h3005, 16'h0000, 3'd1, 1'b1, 3, 16'hBEEF, 0, 16'h0);
    do_op(OP_STB, 16'h2001, 16'h1234, 3'd2, 1'b1, 2, 16'h0, 0, 16'h0);
    do_op(OP_STB, 16'h2000, 16'h1234, 3'd2, 1'b1, 1, 16'h0, 0, 16'h0);
    do_op(OP_LDB, 16'h4001, 16'h0000, 3'd4, 1'b1, 2, 16'h80FF, 0, 16'h0);
    do_op(OP_LDB, 16'h4000, 16'h0000, 3'd5, 1'b1, 1, 16'h80FF, 0, 16'h0);
    do_op(OP_LDI, 16'h1000, 16'h0000, 3'd6, 1'b1, 2, 16'h5001, 3, 16'hCAFE);
    do_op(OP_STI, 16'h1000, 16'h4444, 3'd7, 1'b1, 1, 16'h5001, 2, 16'h0);
    do_op(OP_ADD, 16'h0000, 16'h0007, 3'd3, 1'b1, 0, 16'h0, 0, 16'h0);
    do_op(OP_LDR, 16'h0100, 16'h0055, 3'd2, 1'b0, 0, 16'h0, 0, 16'h0);

    for (int i = 0; i < 60; i++) begin
      do_op(ops[$urandom_range(0, 7)], 16'($urandom), 16'($urandom), 3'($urandom),
            ($urandom % 5) != 0, $urandom_range(1, 4), 16'($urandom),
            $urandom_range(1, 4), 16'($urandom));
    end

    // Reset while the second indirect access is outstanding.
    valid_in = 1'b1; opcode_in = OP_LDI; mem_read_in = 1'b1; mem_write_in = 1'b0;
    address_in = 16'h0800; result_in = '0; dr_in = 3'd1;
    @(negedge clk); dmem_resp = 1'b1; dmem_rdata = 16'h6000;
    @(negedge clk); dmem_resp = 1'b0;
    @(negedge clk); #1;
    chk("ind_data_rd", dmem_read, 1);
    chk("ind_data_addr", dmem_address, 16'h6000);
    @(negedge clk); reset = 1'b1; #1;
    chk("rst_mid_strobes", {dmem_read, dmem_write}, 0);
    @(negedge clk); reset = 1'b0; bubble(); dmem_resp = 1'b1; dmem_rdata = 16'h7777; #1;
    chk("rst_mid_valid", valid_out, 0);
    chk("stray_strobes", {dmem_read, dmem_write}, 0);
    chk("stray_stall", mem_stall, 0);
    @(negedge clk); dmem_resp = 1'b0; #1;
    chk("stray_valid", valid_out, 0);

    // Withheld response drives the timeout flag.
    valid_in = 1'b1; opcode_in = OP_LDR; mem_read_in = 1'b1; address_in = 16'h0A0A; dr_in = 3'd2;
    for (int n = 1; n <= 256; n++) begin
      @(negedge clk); #1;
      if (n == 200) chk("to_early", err_timeout, 0);
      if (n == 256) chk("to_set", err_timeout, 1);
    end
    @(negedge clk); dmem_resp = 1'b1; dmem_rdata = 16'h1111; #1;
    chk("to_resp_stall", mem_stall, 0);
    @(negedge clk); dmem_resp = 1'b0; bubble(); #1;
    chk("to_done_valid", valid_out, 1);
    chk("to_done_data", data_out, 16'h1111);
    chk("to_sticky", err_timeout, 1);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0; #1;
    chk("to_cleared", err_timeout, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
